// File: rtl/instr_split_queue.sv
// instr_split_queue
// Circular instruction buffer between fetch and decode. Holds up to DEPTH
// {pc, instr} pairs and presents the MIPS fields of the head entry, along with
// the format class, the extended immediate and the jump target. Flush empties
// the queue on a branch redirect. When the queue is empty, every head-derived
// output is held at zero.

module instr_split_queue #(
    parameter int DEPTH      = 4,
    parameter bit ZEXT_LOGIC = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [5:0]               opcode,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [5:0]               funct,
    output logic [15:0]              imm,
    output logic [25:0]              address,
    output logic [31:0]              imm_ext,
    output logic [31:0]              jump_target,
    output logic [1:0]               fmt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;
    logic [3:0]    pc4_hi;
    logic          is_logic_op;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Pointer and occupancy tracking; flush wins over any push/pop that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are never observed while the queue is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Head entry, forced to zero while the queue is empty so all fields read zero.
    always_comb begin
        head_pc    = '0;
        head_instr = '0;
        if (out_valid) begin
            head_pc    = pc_mem[rd_ptr];
            head_instr = instr_mem[rd_ptr];
        end
    end

    assign out_pc  = head_pc;
    assign opcode  = head_instr[31:26];
    assign rs      = head_instr[25:21];
    assign rt      = head_instr[20:16];
    assign rd      = head_instr[15:11];
    assign shamt   = head_instr[10:6];
    assign funct   = head_instr[5:0];
    assign imm     = head_instr[15:0];
    assign address = head_instr[25:0];

    // Only the top nibble of pc+4 is needed; it carries in when pc[27:2] is all ones.
    assign pc4_hi      = head_pc[31:28] + {3'b000, &head_pc[27:2]};
    assign jump_target = {pc4_hi, head_instr[25:0], 2'b00};

    // Format class and immediate extension decoded from the head opcode.
    always_comb begin
        fmt         = 2'd1;
        is_logic_op = (opcode == 6'h0c) || (opcode == 6'h0d) || (opcode == 6'h0e);
        imm_ext     = {{16{imm[15]}}, imm};
        if (opcode == 6'h00) begin
            fmt = 2'd0;
        end else if (opcode == 6'h02 || opcode == 6'h03) begin
            fmt = 2'd2;
        end
        if (ZEXT_LOGIC && is_logic_op) begin
            imm_ext = {16'h0000, imm};
        end
    end

endmodule
